// File: rtl/scan_gray_seq.sv
// Gray-code sequencer plus capture register on one full-scan chain, with a
// loop-scan controller that rotates the chain out serially and restores it.
module scan_gray_seq #(
    parameter int WIDTH = 2,
    parameter int CAP_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cap_en,
    input  logic [CAP_W-1:0] cap_in,
    input  logic             scan_mode,
    input  logic             scan_in,
    input  logic             scan_start,
    output logic [WIDTH-1:0] st_q,
    output logic [CAP_W-1:0] cap_q,
    output logic             scan_out,
    output logic             scan_busy,
    output logic             scan_done
);
    localparam int L  = WIDTH + CAP_W;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_e;

    ctrl_e            ctrl_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] st_r_q;
    logic [CAP_W-1:0] cap_r_q;

    logic [L-1:0]     chain;
    logic [L-1:0]     chain_ext_d;
    logic [L-1:0]     chain_rot_d;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] st_inc_d;

    // Chain bit 0 is st[0]; the tail (bit L-1) is the top capture bit.
    assign chain       = {cap_r_q, st_r_q};
    assign chain_ext_d = {chain[L-2:0], scan_in};
    assign chain_rot_d = {chain[L-2:0], chain[L-1]};

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = st_r_q[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--)
            bin[i] = bin[i+1] ^ st_r_q[i];
        bin_inc  = bin + WIDTH'(1);
        st_inc_d = bin_inc ^ (bin_inc >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_r_q  <= '0;
            cap_r_q <= '0;
            ctrl_q  <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (scan_mode) begin
            // External shift aborts any loop-scan without restoring the chain.
            {cap_r_q, st_r_q} <= chain_ext_d;
            ctrl_q <= IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (ctrl_q == SHIFT) begin
            {cap_r_q, st_r_q} <= chain_rot_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(L - 1)) begin
                ctrl_q <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            if (en)
                st_r_q <= st_inc_d;
            if (cap_en && st_r_q[WIDTH-1])
                cap_r_q <= cap_in;
            done_q <= 1'b0;
            if (ctrl_q == DONE) begin
                ctrl_q <= IDLE;
            end else if (scan_start) begin
                ctrl_q <= SHIFT;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end
        end
    end

    assign st_q      = st_r_q;
    assign cap_q     = cap_r_q;
    assign scan_out  = cap_r_q[CAP_W-1];
    assign scan_busy = busy_q;
    assign scan_done = done_q;
endmodule
